// File: rtl/prog_instr_mem.sv
// Loadable instruction memory for the CAP19 fetch stage: zero-sweep after reset,
// cell-serial load port and a registered, holdable fetch port.
module prog_instr_mem #(
  parameter int CELL_W         = 4,
  parameter int CELLS_PER_WORD = 4,
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 32,
  localparam int IW            = CELL_W * CELLS_PER_WORD,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_valid,
  input  logic [CELL_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              rd_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_hold,
  output logic              rd_valid,
  output logic [IW-1:0]     rd_instr,
  output logic              rd_misaligned
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CPW_A     = AW'(CELLS_PER_WORD);

  state_e            state_q;
  logic [AW-1:0]     ptr_q;
  logic [CELL_W-1:0] mem_q [DEPTH];

  logic              rd_valid_q;
  logic [IW-1:0]     rd_instr_q;
  logic              rd_misaligned_q;

  logic              mem_we;
  logic [CELL_W-1:0] mem_wdata;
  logic [AW-1:0]     rd_cell;
  logic              rd_accept;
  logic [IW-1:0]     rd_word_d;
  logic              rd_misaligned_d;

  // Only the low AW address bits select a cell; the rest are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[ADDR_W-1:AW], rd_addr[ADDR_W-1:AW]};

  assign busy     = (state_q != ST_IDLE);
  assign rd_ready = (state_q == ST_IDLE);
  assign rd_cell  = rd_addr[AW-1:0];

  // A load start in the same cycle wins over a fetch request.
  assign rd_accept = rd_req && rd_ready && !rd_hold && !ld_start;

  assign mem_we    = (state_q == ST_CLEAR) || ((state_q == ST_LOAD) && ld_valid);
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : ld_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_word_d = '0;
    for (int k = 0; k < CELLS_PER_WORD; k++) begin
      rd_word_d[IW-1-k*CELL_W -: CELL_W] = mem_q[rd_cell + AW'(k)];
    end
    rd_misaligned_d = ((rd_cell % CPW_A) != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LAST_CELL) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (ld_start) begin
            ptr_q   <= ld_addr[AW-1:0];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + AW'(1);
            if (ld_last) state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; the post-reset CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q      <= 1'b0;
      rd_instr_q      <= '0;
      rd_misaligned_q <= 1'b0;
    end else if (rd_accept) begin
      rd_valid_q      <= 1'b1;
      rd_instr_q      <= rd_word_d;
      rd_misaligned_q <= rd_misaligned_d;
    end else if (!rd_hold) begin
      rd_valid_q      <= 1'b0;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_instr      = rd_instr_q;
  assign rd_misaligned = rd_misaligned_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed bench for prog_instr_mem: clear sweep, load, wrap, hold, gating, reset mid-load.
module tb_prog_instr_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        ld_start = 1'b0;
  logic [31:0] ld_addr  = '0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        rd_ready;
  logic        rd_req   = 1'b0;
  logic [31:0] rd_addr  = '0;
  logic        rd_hold  = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_instr;
  logic        rd_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  prog_instr_mem #(
    .CELL_W(4), .CELLS_PER_WORD(4), .DEPTH(64), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last),
    .rd_ready(rd_ready), .rd_req(rd_req), .rd_addr(rd_addr), .rd_hold(rd_hold),
    .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_misaligned(rd_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one fetch request and sample the outputs just after the accepting edge.
  task automatic fetch_at(input logic [31:0] addr);
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    rd_req = 1'b1; rd_addr = addr; rd_hold = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load4(input logic [31:0] addr, input logic [15:0] cells);
    @(negedge clk);
    rd_req = 1'b0; rd_hold = 1'b0; ld_start = 1'b1; ld_addr = addr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_start = 1'b0; ld_valid = 1'b1;
      ld_data  = cells[15-4*i -: 4];
      ld_last  = (i == 3);
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) break;
    end
    n_checks++;
    if (cnt !== 64) begin
      n_fail++;
      $display("FAIL %s_clear_len: busy high for %0d cycles, expected 64", tag, cnt);
    end
    n_checks++;
    if (rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: rd_ready=%b expected 1", tag, rd_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, rd_ready, rd_valid, rd_misaligned} !== 4'b1000 || rd_instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b ready=%b valid=%b mis=%b instr=%h expected 1 0 0 0 0000",
               busy, rd_ready, rd_valid, rd_misaligned, rd_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clear("post_reset");
    fetch_at(32'd0);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h0000 || rd_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_cleared: valid=%b instr=%h mis=%b expected 1 0000 0",
               rd_valid, rd_instr, rd_misaligned);
    end
  endtask

  // Load 3,7,0,E at 8 with an idle cycle carrying a stray ld_last in the middle.
  task automatic test_load;
    @(negedge clk);
    rd_req = 1'b0; ld_start = 1'b1; ld_addr = 32'd8;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || rd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_enter: busy=%b ready=%b expected 1 0", busy, rd_ready);
    end
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; ld_data = 4'h3;
    @(negedge clk); ld_valid = 1'b0; ld_last = 1'b1; ld_data = 4'h9;
    @(negedge clk); ld_valid = 1'b1; ld_last = 1'b0; ld_data = 4'h7;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stray_last: busy=%b expected 1", busy);
    end
    @(negedge clk); ld_data = 4'h0;
    @(negedge clk); ld_data = 4'hE; ld_last = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_exit: busy=%b ready=%b expected 0 1", busy, rd_ready);
    end
    fetch_at(32'd8);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h370E || rd_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fetch8: valid=%b instr=%h mis=%b expected 1 370e 0",
               rd_valid, rd_instr, rd_misaligned);
    end
  endtask

  task automatic test_wrap;
    load4(32'd62, 16'hABCD);
    fetch_at(32'd62);
    n_checks++;
    if (rd_instr !== 16'hABCD || rd_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_fetch62: instr=%h mis=%b expected abcd 1", rd_instr, rd_misaligned);
    end
    fetch_at(32'd0);
    n_checks++;
    if (rd_instr !== 16'hCD00 || rd_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_fetch0: instr=%h mis=%b expected cd00 0", rd_instr, rd_misaligned);
    end
  endtask

  task automatic test_back_to_back;
    load4(32'd12, 16'h5AF1);
    fetch_at(32'd8);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h370E) begin
      n_fail++;
      $display("FAIL hold_first: valid=%b instr=%h expected 1 370e", rd_valid, rd_instr);
    end
    @(negedge clk);
    rd_hold = 1'b1; rd_req = 1'b1; rd_addr = 32'd12;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_instr !== 16'h370E) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b instr=%h expected 1 370e", i, rd_valid, rd_instr);
      end
    end
    @(negedge clk); rd_hold = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h5AF1 || rd_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b instr=%h mis=%b expected 1 5af1 0",
               rd_valid, rd_instr, rd_misaligned);
    end
    @(negedge clk); rd_addr = 32'd9;
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h70E5 || rd_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_fetch9: valid=%b instr=%h mis=%b expected 1 70e5 1",
               rd_valid, rd_instr, rd_misaligned);
    end
    @(negedge clk); rd_addr = 32'd14;
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'hF100 || rd_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_fetch14: valid=%b instr=%h mis=%b expected 1 f100 1",
               rd_valid, rd_instr, rd_misaligned);
    end
    @(negedge clk); rd_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_instr !== 16'hF100 || rd_misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_keep: valid=%b instr=%h mis=%b expected 0 f100 1",
               rd_valid, rd_instr, rd_misaligned);
    end
  endtask

  task automatic test_load_gating;
    fetch_at(32'd8);
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_prefetch: valid=%b expected 1", rd_valid);
    end
    @(negedge clk);
    ld_start = 1'b1; ld_addr = 32'd20; rd_req = 1'b1; rd_addr = 32'd12;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_instr !== 16'h370E) begin
      n_fail++;
      $display("FAIL gate_start_priority: busy=%b valid=%b instr=%h expected 1 0 370e",
               busy, rd_valid, rd_instr);
    end
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; ld_data = 4'h9;
    @(posedge clk); #1;
    n_checks++;
    if (rd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_during_load: ready=%b valid=%b expected 0 0", rd_ready, rd_valid);
    end
    @(negedge clk); ld_data = 4'h8; ld_last = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_load_done: busy=%b valid=%b expected 0 0", busy, rd_valid);
    end
    fetch_at(32'd20);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h9800 || rd_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_fetch20: valid=%b instr=%h mis=%b expected 1 9800 0",
               rd_valid, rd_instr, rd_misaligned);
    end
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    rd_req = 1'b0; ld_start = 1'b1; ld_addr = 32'd8;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; ld_data = 4'h1;
    @(negedge clk); ld_data = 4'h2;
    @(negedge clk); ld_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, rd_ready, rd_valid, rd_misaligned} !== 4'b1000 || rd_instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL midload_async_reset: busy=%b ready=%b valid=%b mis=%b instr=%h expected 1 0 0 0 0000",
               busy, rd_ready, rd_valid, rd_misaligned, rd_instr);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clear("midload");
    fetch_at(32'd8);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL midload_erased8: valid=%b instr=%h expected 1 0000", rd_valid, rd_instr);
    end
    fetch_at(32'd12);
    n_checks++;
    if (rd_instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL midload_erased12: instr=%h expected 0000", rd_instr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_back_to_back();
    test_load_gating();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_instr_mem.md
# prog_instr_mem

Parametrised, loadable instruction memory for the CAP19 pipeline fetch stage. Replaces fixed, reset-initialised program contents with a runtime cell-serial load port, a self-clearing sweep after reset, and a registered fetch port with request/hold handshaking. Instructions are assembled big-endian from `CELLS_PER_WORD` consecutive memory cells, with addresses wrapping modulo `DEPTH`.

## Interface
- `CELL_W`, 4: bits per memory cell.
- `CELLS_PER_WORD`, 4: cells concatenated per instruction; instruction width `IW = CELL_W*CELLS_PER_WORD`.
- `DEPTH`, 64: number of cells; power of two, ≥ `CELLS_PER_WORD`. `AW = $clog2(DEPTH)`.
- `ADDR_W`, 32: width of the incoming address buses; only the low `AW` bits are used.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `busy` out 1: high in CLEAR or LOAD.
- `ld_start` in 1: begin a load session (accepted in IDLE only).
- `ld_addr` in `ADDR_W`: start cell address, sampled with `ld_start`.
- `ld_valid` in 1: `ld_data` is valid this cycle (LOAD only).
- `ld_data` in `CELL_W`: cell to write.
- `ld_last` in 1: with `ld_valid`, marks the final cell of the session.
- `rd_ready` out 1: high in IDLE; fetch requests are accepted only when it is high.
- `rd_req` in 1: fetch request.
- `rd_addr` in `ADDR_W`: fetch cell address.
- `rd_hold` in 1: stall from the pipeline.
- `rd_valid` out 1: `rd_instr` is valid.
- `rd_instr` out `IW`: fetched instruction.
- `rd_misaligned` out 1: the fetched address was not a multiple of `CELLS_PER_WORD`.

## Operation
- FSM states: CLEAR, IDLE, LOAD. Reset forces CLEAR and sets the sweep pointer to 0.
- CLEAR: writes 0 to cell `ptr` each cycle, then `ptr++`. After the write to `DEPTH-1`, the FSM moves to IDLE. The `ld_*` and `rd_*` inputs are ignored.
- IDLE with `ld_start`: `ptr <= ld_addr[AW-1:0]`, then go to LOAD. `ld_start` takes priority over `rd_req` in the same cycle; that fetch is not accepted.
- LOAD: on `ld_valid`, `mem[ptr] <= ld_data` and `ptr <= (ptr+1) mod DEPTH`. If `ld_last` is also high, return to IDLE. Cycles with `ld_valid` low write nothing. `ld_last` without `ld_valid` is ignored.
- Fetch accept condition: `rd_req && rd_ready && !rd_hold`. With `a = rd_addr[AW-1:0]`:
  - `rd_instr <= {mem[a], mem[(a+1)%DEPTH], …, mem[(a+CELLS_PER_WORD-1)%DEPTH]}`, with `mem[a]` in the MSBs.
  - `rd_misaligned <= (a % CELLS_PER_WORD != 0)`. Misaligned data is still returned.
  - `rd_valid <= 1`.
- `rd_hold` high: `rd_valid`, `rd_instr` and `rd_misaligned` keep their values; no request is accepted.
- No accept and no hold: `rd_valid <= 0`; `rd_instr` and `rd_misaligned` keep their last values.
- Entering LOAD or CLEAR with `rd_hold` low clears `rd_valid` on the next edge.
- Memory contents are never written outside CLEAR and LOAD.

## Timing
- Reset values: `busy=1`, `rd_ready=0`, `rd_valid=0`, `rd_instr=0`, `rd_misaligned=0`, internal `ptr=0`, state CLEAR.
- CLEAR lasts exactly `DEPTH` cycles after the first rising edge with `rst` low. `busy` falls and `rd_ready` rises together, combinationally from the state.
- Fetch latency: 1 cycle. A request accepted at edge N produces valid data after edge N; back-to-back accepts give 1 instruction per cycle.
- Load throughput: 1 cell per cycle. A write at edge N is visible to a fetch accepted at edge N+1 or later. Fetches cannot overlap a load because `rd_ready` is low during LOAD.
- Reset mid-LOAD or mid-CLEAR: state restarts in CLEAR, partial load contents are erased, all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset release: `busy` is high for exactly 64 cycles and `rd_ready` rises at cycle 64. Then fetch addr 0 -> `rd_valid=1`, `rd_instr=16'h0000` one cycle later.
- Load from 8: cells 3,7,0,E, last on E -> IDLE. Then fetch 8 -> `rd_instr=16'h370E`, `rd_misaligned=0`.
- Wrap-around: load from 62 with cells A,B,C,D (lands in 62,63,0,1). Fetch 62 -> `16'hABCD`, `rd_misaligned=1`. Fetch 0 -> `16'hCD00`.
- Hold: accept fetch 8, then hold for 3 cycles with `rd_req=1`, `rd_addr=12`. `rd_instr` stays `16'h370E` and `rd_valid` stays 1. The cycle after hold drops, `rd_instr` shows the contents at 12.
- Load gating: fetch request asserted during LOAD -> `rd_ready=0` and `rd_valid` stays 0. `ld_start` and `rd_req` in the same IDLE cycle -> enters LOAD, no `rd_valid`.
- Reset mid-load: after 2 of 4 cells are written at 8, pulse `rst` -> outputs reset at once. After 64 CLEAR cycles, fetch 8 -> `16'h0000`.
